// File: rtl/shift_deser8_if.sv
// Bus interface for the shift_deser8 serial-to-parallel deserializer.
// The parity_err signal exists only when SHIFT_DESER8_PARITY_EN is defined.
interface shift_deser8_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             frame_start;
    logic             serial_in;
    logic             msb_first;
    logic             data_ready;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             busy;
    logic             overrun;
`ifdef SHIFT_DESER8_PARITY_EN
    logic             parity_err;
`endif

    // Deserializer side
    modport slave (
        input  enable, frame_start, serial_in, msb_first, data_ready,
`ifdef SHIFT_DESER8_PARITY_EN
        output parity_err,
`endif
        output data_out, data_valid, busy, overrun
    );

    // Producer/consumer side
    modport master (
        output enable, frame_start, serial_in, msb_first, data_ready,
`ifdef SHIFT_DESER8_PARITY_EN
        input  parity_err,
`endif
        input  data_out, data_valid, busy, overrun
    );
endinterface

// File: rtl/shift_deser8.sv
// shift_deser8: serial-to-parallel deserializer with frame start, bit-order
// select, ready/valid output handshake and a sticky overrun flag.
// Optional feature macro: SHIFT_DESER8_PARITY_EN adds an even-parity bit
// after the data bits and the parity_err output.
module shift_deser8 #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    shift_deser8_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef SHIFT_DESER8_PARITY_EN
    localparam logic [1:0] S_PARITY = 2'd2;
`endif
    localparam logic [1:0] S_HOLD   = 2'd3;

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef SHIFT_DESER8_PARITY_EN
    // Even parity: error when data bits plus parity bit have odd weight.
    function automatic logic even_parity_err(input logic [WIDTH-1:0] d, input logic p);
        return ^{d, p};
    endfunction
`endif

    logic [1:0]       r_state,  w_state_n;
    logic [WIDTH-1:0] r_shreg,  w_shreg_n;
    logic [CW-1:0]    r_count,  w_count_n;
    logic             r_msb,    w_msb_n;
    logic [WIDTH-1:0] r_dout,   w_dout_n;
    logic             r_valid,  w_valid_n;
    logic             r_busy,   w_busy_n;
    logic             r_ovr,    w_ovr_n;
`ifdef SHIFT_DESER8_PARITY_EN
    logic             r_perr,   w_perr_n;
`endif

    logic             w_start;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_first;

    assign w_start = bus.enable & bus.frame_start;
    // Shift uses the order latched at frame start; the first bit uses the live input.
    assign w_shift = r_msb ? {r_shreg[WIDTH-2:0], bus.serial_in}
                           : {bus.serial_in, r_shreg[WIDTH-1:1]};
    assign w_first = bus.msb_first ? {{(WIDTH-1){1'b0}}, bus.serial_in}
                                   : {bus.serial_in, {(WIDTH-1){1'b0}}};

    // Next-state and next-output computation for the framing FSM.
    always_comb begin
        w_state_n = r_state;
        w_shreg_n = r_shreg;
        w_count_n = r_count;
        w_msb_n   = r_msb;
        w_dout_n  = r_dout;
        w_valid_n = r_valid;
        w_ovr_n   = r_ovr;
`ifdef SHIFT_DESER8_PARITY_EN
        w_perr_n  = r_perr;
`endif
        // Consumer accepts a pending word in any state.
        if (r_valid && bus.data_ready) begin
            w_valid_n = 1'b0;
        end else begin
            w_valid_n = r_valid;
        end
        // A new frame while a word is still unaccepted is an overrun.
        if (w_start && r_valid && !bus.data_ready) begin
            w_ovr_n = 1'b1;
        end else begin
            w_ovr_n = r_ovr;
        end

        // A qualified frame_start always (re)starts a frame, in any state.
        if (w_start) begin
            w_state_n = S_SHIFT;
            w_shreg_n = w_first;
            w_count_n = CW'(1);
            w_msb_n   = bus.msb_first;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_n = S_IDLE;
                end
                S_SHIFT: begin
                    if (bus.enable) begin
                        w_shreg_n = w_shift;
                        w_count_n = r_count + CW'(1);
                        if (r_count == LAST_CNT) begin
                            w_dout_n  = w_shift;
`ifdef SHIFT_DESER8_PARITY_EN
                            w_state_n = S_PARITY;
`else
                            w_state_n = S_HOLD;
                            w_valid_n = 1'b1;
`endif
                        end else begin
                            w_state_n = S_SHIFT;
                        end
                    end else begin
                        w_state_n = S_SHIFT;
                    end
                end
`ifdef SHIFT_DESER8_PARITY_EN
                S_PARITY: begin
                    if (bus.enable) begin
                        w_state_n = S_HOLD;
                        w_valid_n = 1'b1;
                        w_perr_n  = even_parity_err(r_dout, bus.serial_in);
                    end else begin
                        w_state_n = S_PARITY;
                    end
                end
`endif
                S_HOLD: begin
                    if (bus.data_ready) begin
                        w_state_n = S_IDLE;
                    end else begin
                        w_state_n = S_HOLD;
                    end
                end
                default: begin
                    w_state_n = S_IDLE;
                end
            endcase
        end

`ifdef SHIFT_DESER8_PARITY_EN
        w_busy_n = (w_state_n == S_SHIFT) || (w_state_n == S_PARITY);
`else
        w_busy_n = (w_state_n == S_SHIFT);
`endif
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_shreg <= {WIDTH{1'b0}};
            r_count <= {CW{1'b0}};
            r_msb   <= 1'b0;
            r_dout  <= {WIDTH{1'b0}};
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
`ifdef SHIFT_DESER8_PARITY_EN
            r_perr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_n;
            r_shreg <= w_shreg_n;
            r_count <= w_count_n;
            r_msb   <= w_msb_n;
            r_dout  <= w_dout_n;
            r_valid <= w_valid_n;
            r_busy  <= w_busy_n;
            r_ovr   <= w_ovr_n;
`ifdef SHIFT_DESER8_PARITY_EN
            r_perr  <= w_perr_n;
`endif
        end
    end

    assign bus.data_out   = r_dout;
    assign bus.data_valid = r_valid;
    assign bus.busy       = r_busy;
    assign bus.overrun    = r_ovr;
`ifdef SHIFT_DESER8_PARITY_EN
    assign bus.parity_err = r_perr;
`endif

endmodule

// File: tb/tb_shift_deser8.sv
// Directed testbench for shift_deser8 (default build; parity scenario only
// when SHIFT_DESER8_PARITY_EN is defined).
module tb_shift_deser8;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    shift_deser8_if #(.WIDTH(8)) bus();

    shift_deser8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive bits [from..to] of word w; bit 0 of the frame carries frame_start.
    // msb_first is inverted after the first bit to show it is latched.
    task automatic drive_bits(input logic [7:0] w, input logic msb,
                              input int from, input int to, input logic gap);
        for (int i = from; i <= to; i++) begin
            bus.enable      = 1'b1;
            bus.frame_start = (i == 0);
            bus.msb_first   = (i == 0) ? msb : ~msb;
            bus.serial_in   = msb ? w[7-i] : w[i];
            tick();
            if (gap) begin
                bus.enable      = 1'b0;
                bus.frame_start = 1'b1;
                bus.serial_in   = ~bus.serial_in;
                tick();
            end
        end
        bus.enable      = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic accept();
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (bus.data_out !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", bus.data_out); end
        checks++; if (bus.data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.data_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", bus.overrun); end
        reset = 1'b1;
    endtask

    task automatic test_msb_first();
        drive_bits(8'hA5, 1'b1, 0, 6, 1'b0);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL msb_busy7 got=%b exp=1", bus.busy); end
        checks++; if (bus.data_valid !== 1'b0) begin failures++; $display("FAIL msb_valid7 got=%b exp=0", bus.data_valid); end
        drive_bits(8'hA5, 1'b1, 7, 7, 1'b0);
        checks++; if (bus.data_out !== 8'hA5) begin failures++; $display("FAIL msb_dout got=%h exp=a5", bus.data_out); end
        checks++; if (bus.data_valid !== 1'b1) begin failures++; $display("FAIL msb_valid got=%b exp=1", bus.data_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL msb_busy got=%b exp=0", bus.busy); end
        tick();
        checks++; if (bus.data_valid !== 1'b1) begin failures++; $display("FAIL msb_hold got=%b exp=1", bus.data_valid); end
        accept();
        checks++; if (bus.data_valid !== 1'b0) begin failures++; $display("FAIL msb_accept got=%b exp=0", bus.data_valid); end
    endtask

    task automatic test_bit_order();
        drive_bits(8'h03, 1'b0, 0, 7, 1'b0);
        checks++; if (bus.data_out !== 8'h03) begin failures++; $display("FAIL lsb_dout got=%h exp=03", bus.data_out); end
        accept();
        drive_bits(8'hC0, 1'b1, 0, 7, 1'b0);
        checks++; if (bus.data_out !== 8'hC0) begin failures++; $display("FAIL msb_c0 got=%h exp=c0", bus.data_out); end
        accept();
    endtask

    task automatic test_enable_gaps();
        drive_bits(8'h96, 1'b1, 0, 3, 1'b1);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL gap_busy got=%b exp=1", bus.busy); end
        drive_bits(8'h96, 1'b1, 4, 7, 1'b1);
        checks++; if (bus.data_out !== 8'h96) begin failures++; $display("FAIL gap_dout got=%h exp=96", bus.data_out); end
        checks++; if (bus.data_valid !== 1'b1) begin failures++; $display("FAIL gap_valid got=%b exp=1", bus.data_valid); end
        accept();
    endtask

    task automatic test_back_to_back();
        drive_bits(8'h3C, 1'b1, 0, 7, 1'b0);
        checks++; if (bus.data_out !== 8'h3C) begin failures++; $display("FAIL b2b_first got=%h exp=3c", bus.data_out); end
        bus.data_ready = 1'b1;
        drive_bits(8'h81, 1'b1, 0, 0, 1'b0);
        bus.data_ready = 1'b0;
        checks++; if (bus.data_valid !== 1'b0) begin failures++; $display("FAIL b2b_accept got=%b exp=0", bus.data_valid); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", bus.busy); end
        drive_bits(8'h81, 1'b1, 1, 7, 1'b0);
        checks++; if (bus.data_out !== 8'h81) begin failures++; $display("FAIL b2b_dout got=%h exp=81", bus.data_out); end
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL b2b_ovr got=%b exp=0", bus.overrun); end
    endtask

    // Continues with 8'h81 still pending from the back-to-back scenario.
    task automatic test_overrun();
        drive_bits(8'h0F, 1'b1, 0, 0, 1'b0);
        checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", bus.overrun); end
        checks++; if (bus.data_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", bus.data_valid); end
        drive_bits(8'h0F, 1'b1, 1, 6, 1'b0);
        checks++; if (bus.data_out !== 8'h81) begin failures++; $display("FAIL ovr_keep got=%h exp=81", bus.data_out); end
        drive_bits(8'h0F, 1'b1, 7, 7, 1'b0);
        checks++; if (bus.data_out !== 8'h0F) begin failures++; $display("FAIL ovr_new got=%h exp=0f", bus.data_out); end
        accept();
        checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", bus.overrun); end
    endtask

    task automatic test_mid_abort();
        drive_bits(8'hFF, 1'b1, 0, 2, 1'b0);
        drive_bits(8'h66, 1'b1, 0, 7, 1'b0);
        checks++; if (bus.data_out !== 8'h66) begin failures++; $display("FAIL abort_dout got=%h exp=66", bus.data_out); end
        checks++; if (bus.data_valid !== 1'b1) begin failures++; $display("FAIL abort_valid got=%b exp=1", bus.data_valid); end
        accept();
    endtask

    task automatic test_reset_mid_frame();
        drive_bits(8'hFF, 1'b1, 0, 3, 1'b0);
        reset           = 1'b0;
        bus.enable      = 1'b1;
        bus.frame_start = 1'b1;
        bus.serial_in   = 1'b1;
        tick();
        bus.enable      = 1'b0;
        bus.frame_start = 1'b0;
        reset           = 1'b1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL rstmid_ovr got=%b exp=0", bus.overrun); end
        checks++; if (bus.data_out !== 8'h00) begin failures++; $display("FAIL rstmid_dout got=%h exp=00", bus.data_out); end
        drive_bits(8'h5A, 1'b1, 0, 7, 1'b0);
        checks++; if (bus.data_out !== 8'h5A) begin failures++; $display("FAIL rstmid_5a got=%h exp=5a", bus.data_out); end
        checks++; if (bus.data_valid !== 1'b1) begin failures++; $display("FAIL rstmid_valid got=%b exp=1", bus.data_valid); end
        accept();
    endtask

`ifdef SHIFT_DESER8_PARITY_EN
    task automatic test_parity();
        for (int k = 0; k < 2; k++) begin
            drive_bits(8'h07, 1'b1, 0, 7, 1'b0);
            checks++; if (bus.data_valid !== 1'b0) begin failures++; $display("FAIL par_pre got=%b exp=0", bus.data_valid); end
            bus.enable    = 1'b1;
            bus.serial_in = (k == 0);
            tick();
            bus.enable    = 1'b0;
            checks++; if (bus.data_valid !== 1'b1) begin failures++; $display("FAIL par_valid got=%b exp=1", bus.data_valid); end
            checks++; if (bus.parity_err !== (k == 1)) begin failures++; $display("FAIL par_err got=%b exp=%b", bus.parity_err, (k == 1)); end
            accept();
        end
    endtask
`endif

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b0;
        bus.enable      = 1'b0;
        bus.frame_start = 1'b0;
        bus.serial_in   = 1'b0;
        bus.msb_first   = 1'b1;
        bus.data_ready  = 1'b0;
        test_reset();
`ifdef SHIFT_DESER8_PARITY_EN
        test_parity();
`else
        test_msb_first();
        test_bit_order();
        test_enable_gaps();
        test_back_to_back();
        test_overrun();
        test_mid_abort();
        test_reset_mid_frame();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_deser8.md
SHIFT_DESER8 -- requirements
Module: shift_deser8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, which is the number of data bits per frame (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 SHALL have port reset, input, 1 bit; reset is synchronous and active-low.
REQ-004 SHALL have port enable, input, 1 bit, the bit strobe: serial_in is sampled only on clock edges where enable=1.
REQ-005 SHALL have port frame_start, input, 1 bit, marking the first bit of a frame; it is qualified by enable.
REQ-006 SHALL have port serial_in, input, 1 bit, the serial data bit.
REQ-007 SHALL have port msb_first, input, 1 bit, the bit order (1 = MSB first, 0 = LSB first); it is latched at frame start.
REQ-008 SHALL have port data_ready, input, 1 bit, the consumer accept signal.
REQ-009 SHALL have port data_out, output, WIDTH bits, the last completed word.
REQ-010 SHALL have port data_valid, output, 1 bit, high while a completed word awaits acceptance.
REQ-011 SHALL have port busy, output, 1 bit, high while a frame is being assembled.
REQ-012 SHALL have port overrun, output, 1 bit, a sticky flag set when a frame starts while an unaccepted word is pending.

Function
REQ-013 SHALL implement a state machine with states IDLE, SHIFT, PARITY (present only with the macro) and HOLD.
REQ-014 IDLE: on enable&frame_start, SHALL load serial_in as bit 1, set count=1, latch msb_first and go to SHIFT; enable without frame_start is ignored.
REQ-015 SHIFT: each enable SHALL shift in serial_in and increment count; msb_first=1 gives shreg<={shreg[W-2:0],serial_in}, msb_first=0 gives shreg<={serial_in,shreg[W-1:1]}.
REQ-016 When the WIDTH-th bit is sampled, SHALL go to HOLD (or to PARITY with the macro), and in the same edge copy the assembled word into data_out.
REQ-017 data_valid SHALL rise on the clock edge that captures the last bit, so it is visible the cycle after that bit's strobe.
REQ-018 HOLD: data_valid=1 and data_out stable; data_valid&data_ready SHALL clear data_valid and return to IDLE.
REQ-019 HOLD with data_ready=1 and enable&frame_start in the same cycle SHALL accept the word and start a new frame with that bit (back-to-back, no lost bit).
REQ-020 HOLD with data_ready=0 and enable&frame_start SHALL set overrun, keep data_out/data_valid unchanged, and start assembling the new frame in shreg (state SHIFT, data_valid held until accepted or overwritten).
REQ-021 When a new word completes while data_valid is still 1, SHALL overwrite data_out and keep overrun set.
REQ-022 frame_start&enable in SHIFT (mid-frame) SHALL abort the partial frame and restart with count=1 using the current bit; data_out is unaffected.
REQ-023 busy SHALL be 1 in SHIFT and PARITY and 0 otherwise; overrun SHALL clear only on reset.
REQ-024 count SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap past WIDTH.

Reset
REQ-025 On a clock edge with reset=0: state=IDLE, shreg=0, count=0, data_out=0, data_valid=0, busy=0, overrun=0, parity_err=0; this SHALL apply mid-frame, and the partial word is discarded.
REQ-026 Inputs SHALL be ignored on the reset edge, and the first frame_start is accepted on the first edge with reset=1.

Configuration
REQ-027 Macro SHIFT_DESER8_PARITY_EN: when defined, SHALL add output parity_err (1 bit) and state PARITY: after the last data bit, the next enable samples the parity bit (even parity), then the FSM goes to HOLD with data_valid set and parity_err = XOR(data_out, parity bit).
REQ-028 With the macro, data_valid SHALL rise the cycle after the parity strobe; frame_start in PARITY SHALL behave as in REQ-022.
REQ-029 Without the macro, the parity_err port and the PARITY state SHALL not exist, and the timing is as in REQ-016/017.

Verification
REQ-030 msb_first=1, bits 1,0,1,0,0,1,0,1 with enable every cycle, data_ready=0 -> data_out=8'hA5, data_valid high 1 cycle after the 8th bit, busy low.
REQ-031 msb_first=0, same bits -> data_out=8'hA5 bit-reversed = 8'hA5 reversed -> 8'hA5 gives 8'hA5? Use bits 1,1,0,0,0,0,0,0 -> data_out=8'h03; with msb_first=1 -> 8'hC0.
REQ-032 Back-to-back: word 8'h3C pending, data_ready=1 with frame_start of word 8'h81 -> 8'h3C accepted, 8'h81 completes, overrun=0, no bit lost.
REQ-033 Overrun: word pending, data_ready=0, new frame_start -> overrun=1 next cycle, data_out unchanged until the new word completes.
REQ-034 reset=0 after 4 bits of a frame -> all outputs 0 next edge; a subsequent full frame of 8'h5A decodes correctly.
REQ-035 With SHIFT_DESER8_PARITY_EN: 8'h07 with parity bit 1 -> parity_err=0; with parity bit 0 -> parity_err=1; data_valid asserted 1 cycle after the parity strobe.
